s1494_cone_driver: RTL and testbench

Sequential test driver for the combinational partial-output cones extracted from s1494 (e.g. the n65 cone). It receives a serial stimulus vector, presents it in parallel to the cone's 14 inputs, waits a programmable settle time, and captures the cone's output(s). It then returns the captured bits serially over a valid/ready stream. It sits between the bench/scan controller and the unclocked cone, restoring the register boundary that the combinational conversion removed.

---
 rtl/s1494_cone_driver_if.sv | 20 ++
 rtl/s1494_cone_driver.sv | 149 ++++++++++++++
 tb/tb_s1494_cone_driver.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/s1494_cone_driver_if.sv
// Serial stimulus-in and result-out streams of the s1494 cone driver.
// The slave side is the driver; the master side is the bench/scan controller.
interface s1494_cone_driver_if;
  logic si_valid;
  logic si_ready;
  logic si_data;
  logic so_valid;
  logic so_ready;
  logic so_data;

  modport slave (
    input  si_valid, si_data, so_ready,
    output si_ready, so_valid, so_data
  );

  modport master (
    output si_valid, si_data, so_ready,
    input  si_ready, so_valid, so_data
  );
endinterface

// File: rtl/s1494_cone_driver.sv
// Sequential wrapper for an unclocked s1494 output cone: serial vector in,
// parallel apply, settle, capture, serial result out.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// ST_IDLE      | waiting for the first stimulus bit; vec holds last vector
// ST_SHIFT_IN  | collecting stimulus bits 1..NIN-1 into shreg
// ST_SETTLE    | new vec applied, waiting SETTLE cycles for the cone
// ST_CAPTURE   | cone_out sampled into cap on the edge leaving this state
// ST_SHIFT_OUT | returning cap bits, cap[0] first, then done pulse
module s1494_cone_driver #(
  parameter int NIN    = 14,
  parameter int NOUT   = 1,
  parameter int SETTLE = 2
) (
  input  logic                CK,
  input  logic                CLR,
  s1494_cone_driver_if.slave  sif,
  output logic [NIN-1:0]      vec,
  input  logic [NOUT-1:0]     cone_out,
  output logic                busy,
  output logic                done
);

  localparam int IW = $clog2(NIN + 1);
  localparam int SW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam int OW = $clog2(NOUT + 1);

  localparam logic [IW-1:0] IN_LAST  = IW'(NIN - 1);
  localparam logic [SW-1:0] SET_LAST = (SETTLE > 0) ? SW'(SETTLE - 1) : '0;
  localparam logic [OW-1:0] OUT_LAST = OW'(NOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT_IN,
    ST_SETTLE,
    ST_CAPTURE,
    ST_SHIFT_OUT
  } state_t;

  state_t          state, state_n;
  logic [NIN-1:0]  shreg, shreg_n;
  logic [NIN-1:0]  vec_n;
  logic [NOUT-1:0] cap, cap_n;
  logic [IW-1:0]   in_cnt, in_cnt_n;
  logic [SW-1:0]   set_cnt, set_cnt_n;
  logic [OW-1:0]   out_cnt, out_cnt_n;
  logic            done_n;
  logic            cap_bit;

  always_ff @(posedge CK) begin
    if (CLR) begin
      state   <= ST_IDLE;
      shreg   <= '0;
      vec     <= '0;
      cap     <= '0;
      in_cnt  <= '0;
      set_cnt <= '0;
      out_cnt <= '0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      shreg   <= shreg_n;
      vec     <= vec_n;
      cap     <= cap_n;
      in_cnt  <= in_cnt_n;
      set_cnt <= set_cnt_n;
      out_cnt <= out_cnt_n;
      done    <= done_n;
    end
  end

  // Explicit mux keeps the counter width independent of the cap index width.
  always_comb begin
    cap_bit = 1'b0;
    for (int i = 0; i < NOUT; i++) begin
      if (out_cnt == OW'(i)) cap_bit = cap[i];
    end
  end

  always_comb begin
    state_n      = state;
    shreg_n      = shreg;
    vec_n        = vec;
    cap_n        = cap;
    in_cnt_n     = in_cnt;
    set_cnt_n    = set_cnt;
    out_cnt_n    = out_cnt;
    done_n       = 1'b0;
    sif.si_ready = 1'b0;
    sif.so_valid = 1'b0;
    sif.so_data  = 1'b0;
    busy         = (state != ST_IDLE);

    case (state)
      ST_IDLE: begin
        sif.si_ready = 1'b1;
        if (sif.si_valid) begin
          shreg_n[0] = sif.si_data;
          in_cnt_n   = IW'(1);
          state_n    = ST_SHIFT_IN;
        end
      end

      ST_SHIFT_IN: begin
        sif.si_ready = 1'b1;
        if (sif.si_valid) begin
          for (int i = 0; i < NIN; i++) begin
            if (in_cnt == IW'(i)) shreg_n[i] = sif.si_data;
          end
          in_cnt_n = in_cnt + IW'(1);
          if (in_cnt == IN_LAST) begin
            // Apply the completed vector on the same edge as its last bit.
            vec_n     = shreg_n;
            in_cnt_n  = '0;
            set_cnt_n = '0;
            state_n   = (SETTLE == 0) ? ST_CAPTURE : ST_SETTLE;
          end
        end
      end

      ST_SETTLE: begin
        set_cnt_n = set_cnt + SW'(1);
        if (set_cnt == SET_LAST) state_n = ST_CAPTURE;
      end

      ST_CAPTURE: begin
        cap_n     = cone_out;
        out_cnt_n = '0;
        state_n   = ST_SHIFT_OUT;
      end

      ST_SHIFT_OUT: begin
        sif.so_valid = 1'b1;
        sif.so_data  = cap_bit;
        if (sif.so_ready) begin
          out_cnt_n = out_cnt + OW'(1);
          if (out_cnt == OUT_LAST) begin
            done_n  = 1'b1;
            state_n = ST_IDLE;
          end
        end
      end

      default: state_n = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_s1494_cone_driver.sv
// Scoreboard bench for s1494_cone_driver: one instance with 4 captured outputs
// and SETTLE=2, one with a single output and SETTLE=0.
module tb_s1494_cone_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        clr_a, clr_c;
  logic [13:0] vec_a, vec_c;
  logic [3:0]  cone_a;
  logic [0:0]  cone_c;
  logic        busy_a, done_a, busy_c, done_c;

  s1494_cone_driver_if ifa ();
  s1494_cone_driver_if ifc ();

  s1494_cone_driver #(.NIN(14), .NOUT(4), .SETTLE(2)) dut_a (
    .CK(clk), .CLR(clr_a), .sif(ifa), .vec(vec_a),
    .cone_out(cone_a), .busy(busy_a), .done(done_a)
  );

  s1494_cone_driver #(.NIN(14), .NOUT(1), .SETTLE(0)) dut_c (
    .CK(clk), .CLR(clr_c), .sif(ifc), .vec(vec_c),
    .cone_out(cone_c), .busy(busy_c), .done(done_c)
  );

  int   errors = 0;
  int   checks = 0;
  bit   q_a[$];
  bit   q_c[$];
  bit   mon_on = 1'b0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endfunction

  function automatic void fail_now(input string nm, input string what);
    checks++;
    errors++;
    $display("FAIL %s %s at %0t", nm, what, $time);
  endfunction

  // Monitor A: pops expected bits on each transfer, checks hold during stalls and done timing.
  initial begin
    logic pv, px, pd, exp_done;
    bit   e;
    pv = 0; px = 0; pd = 0; exp_done = 0;
    forever begin
      @(negedge clk);
      if (!mon_on) continue;
      if (clr_a) begin
        exp_done = 0;
        pv = 0;
        continue;
      end
      chk("done_a", 32'(done_a), 32'(exp_done));
      exp_done = 0;
      if (pv && !px) chk("so_hold_a", 32'({ifa.so_valid, ifa.so_data}), 32'({1'b1, pd}));
      pv = ifa.so_valid;
      pd = ifa.so_data;
      px = ifa.so_valid && ifa.so_ready;
      if (px) begin
        if (q_a.size() == 0) fail_now("out_a", "actual=unexpected bit required=none");
        else begin
          e = q_a.pop_front();
          chk("so_data_a", 32'(ifa.so_data), 32'(e));
          if (q_a.size() == 0) exp_done = 1;
        end
      end
    end
  end

  initial begin
    logic exp_done;
    bit   e;
    exp_done = 0;
    forever begin
      @(negedge clk);
      if (!mon_on) continue;
      if (clr_c) begin
        exp_done = 0;
        continue;
      end
      chk("done_c", 32'(done_c), 32'(exp_done));
      exp_done = 0;
      if (ifc.so_valid && ifc.so_ready) begin
        if (q_c.size() == 0) fail_now("out_c", "actual=unexpected bit required=none");
        else begin
          e = q_c.pop_front();
          chk("so_data_c", 32'(ifc.so_data), 32'(e));
          if (q_c.size() == 0) exp_done = 1;
        end
      end
    end
  end

  task automatic send(input int d, input logic b);
    int   n;
    logic rdy;
    n = 0;
    rdy = 0;
    if (d == 0) begin ifa.si_valid = 1; ifa.si_data = b; end
    else        begin ifc.si_valid = 1; ifc.si_data = b; end
    do begin
      @(negedge clk);
      rdy = (d == 0) ? ifa.si_ready : ifc.si_ready;
      @(posedge clk); #1;
      n++;
    end while (!rdy && n < 60);
    if (!rdy) fail_now("send_timeout", "actual=si_ready low required=accept");
  endtask

  task automatic shift_vec(input int d, input logic [13:0] v, input int gap_after,
                           input int gap_len, input logic [13:0] old_vec);
    for (int i = 0; i < 14; i++) begin
      send(d, v[i]);
      if (i == gap_after) begin
        if (d == 0) ifa.si_valid = 0; else ifc.si_valid = 0;
        for (int g = 0; g < gap_len; g++) begin
          @(negedge clk);
          chk("si_ready_gap", 32'((d == 0) ? ifa.si_ready : ifc.si_ready), 32'(1));
          chk("vec_hold_gap", 32'((d == 0) ? vec_a : vec_c), 32'(old_vec));
          @(posedge clk); #1;
        end
      end
    end
    if (d == 0) ifa.si_valid = 0; else ifc.si_valid = 0;
  endtask

  task automatic wait_done(input int d);
    int n;
    n = 0;
    while (((d == 0) ? done_a : done_c) !== 1'b1 && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 60) fail_now("done_timeout", "actual=no done required=done pulse");
  endtask

  task automatic wait_valid_a();
    int n;
    n = 0;
    while (ifa.so_valid !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("so_valid_seen_a", 32'(ifa.so_valid), 32'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=still running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          pat [7];
    logic [13:0] v2;
    int          n;
    pat = '{1, 0, 0, 1, 1, 0, 1};
    v2  = 14'h3A96;

    clr_a = 1; clr_c = 1;
    ifa.si_valid = 0; ifa.si_data = 0; ifa.so_ready = 1;
    ifc.si_valid = 0; ifc.si_data = 0; ifc.so_ready = 1;
    cone_a = '0; cone_c = '0;
    repeat (2) @(posedge clk);
    #1;
    clr_a = 0; clr_c = 0;
    chk("rst_si_ready_a", 32'(ifa.si_ready), 32'(1));
    chk("rst_so_valid_a", 32'(ifa.so_valid), 32'(0));
    chk("rst_so_data_a",  32'(ifa.so_data),  32'(0));
    chk("rst_vec_a",      32'(vec_a),        32'(0));
    chk("rst_busy_a",     32'(busy_a),       32'(0));
    chk("rst_done_a",     32'(done_a),       32'(0));
    chk("rst_si_ready_c", 32'(ifc.si_ready), 32'(1));
    chk("rst_vec_c",      32'(vec_c),        32'(0));
    mon_on = 1;

    // n65 job: cone CLR input (vec[1]) low forces n65 (cone_out[0]) to 0.
    cone_a = 4'b0110;
    shift_vec(0, 14'h3FFD, -1, 0, 14'h0000);
    chk("vec_n65", 32'(vec_a), 32'(14'h3FFD));
    chk("busy_n65", 32'(busy_a), 32'(1));
    q_a.push_back(0); q_a.push_back(1); q_a.push_back(1); q_a.push_back(0);
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      chk("so_valid_latency_low", 32'(ifa.so_valid), 32'(0));
    end
    @(negedge clk);
    chk("so_valid_latency_high", 32'(ifa.so_valid), 32'(1));
    @(posedge clk); #1;
    wait_done(0);
    chk("idle_after_done_a", 32'(busy_a), 32'(0));

    // Stimulus gap of 3 cycles between bits 5 and 6.
    cone_a = 4'b1001;
    shift_vec(0, 14'h1B6E, 5, 3, 14'h3FFD);
    chk("vec_gap", 32'(vec_a), 32'(14'h1B6E));
    q_a.push_back(1); q_a.push_back(0); q_a.push_back(0); q_a.push_back(1);
    wait_done(0);

    // Output backpressure; cone_out changes right after capture.
    ifa.so_ready = 0;
    cone_a = 4'b1010;
    shift_vec(0, 14'h2C33, -1, 0, 14'h1B6E);
    q_a.push_back(0); q_a.push_back(1); q_a.push_back(0); q_a.push_back(1);
    wait_valid_a();
    cone_a = 4'b0000;
    for (int p = 0; p < 7; p++) begin
      ifa.so_ready = pat[p][0];
      @(posedge clk); #1;
    end
    ifa.so_ready = 1;
    chk("bp_done", 32'(done_a), 32'(1));
    @(posedge clk); #1;

    // Reset while stalled in SHIFT_OUT.
    ifa.so_ready = 0;
    cone_a = 4'b1111;
    shift_vec(0, 14'h0001, -1, 0, 14'h2C33);
    wait_valid_a();
    clr_a = 1;
    q_a.delete();
    repeat (2) begin @(posedge clk); #1; end
    clr_a = 0;
    chk("mid_rst_si_ready", 32'(ifa.si_ready), 32'(1));
    chk("mid_rst_so_valid", 32'(ifa.so_valid), 32'(0));
    chk("mid_rst_vec",      32'(vec_a),        32'(0));
    chk("mid_rst_busy",     32'(busy_a),       32'(0));
    chk("mid_rst_done",     32'(done_a),       32'(0));
    ifa.so_ready = 1;
    repeat (6) begin @(posedge clk); #1; end
    chk("mid_rst_still_idle", 32'(busy_a), 32'(0));

    // SETTLE=0, back-to-back jobs.
    cone_c = 1'b1;
    shift_vec(1, 14'h0F0F, -1, 0, 14'h0000);
    chk("vec_c_job1", 32'(vec_c), 32'(14'h0F0F));
    q_c.push_back(1);
    ifc.si_valid = 1;
    ifc.si_data  = v2[0];
    @(negedge clk);
    chk("s0_capture_cycle_valid", 32'(ifc.so_valid), 32'(0));
    chk("s0_capture_cycle_busy",  32'(busy_c),       32'(1));
    @(posedge clk); #1;
    cone_c = 1'b0;
    chk("s0_valid_after_capture", 32'(ifc.so_valid), 32'(1));
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ifc.si_ready !== 1'b1 && n < 20);
    chk("b2b_accept_in_done", 32'(done_c), 32'(1));
    @(posedge clk); #1;
    for (int i = 1; i < 14; i++) begin
      if (i == 13) chk("vec_c_hold", 32'(vec_c), 32'(14'h0F0F));
      send(1, v2[i]);
    end
    ifc.si_valid = 0;
    chk("vec_c_job2", 32'(vec_c), 32'(14'h3A96));
    q_c.push_back(0);
    wait_done(1);

    repeat (3) begin @(posedge clk); #1; end
    chk("q_a_drained", q_a.size(), 0);
    chk("q_c_drained", q_c.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
